// File: rtl/adapter_cfg_master.sv
// adapter_cfg_master
// AXI4-Lite write initiator. On each accepted command it programs the BRAM
// adapter with four writes: start address, end address, control with reload,
// then control without reload. All outputs come straight from flops.
module adapter_cfg_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 5,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int BRAM_ADDR_WIDTH    = 12,
   parameter int TIMEOUT_CYCLES     = 256
) (
   input  logic                            m00_axi_aclk,
   input  logic                            m00_axi_areset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_rw,
   input  logic [BRAM_ADDR_WIDTH-1:0]      cmd_start_addr,
   input  logic [BRAM_ADDR_WIDTH-1:0]      cmd_end_addr,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
   output logic [2:0]                      m00_axi_awprot,
   output logic                            m00_axi_awvalid,
   input  logic                            m00_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
   output logic                            m00_axi_wvalid,
   input  logic                            m00_axi_wready,
   input  logic [1:0]                      m00_axi_bresp,
   input  logic                            m00_axi_bvalid,
   output logic                            m00_axi_bready
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ADDR_DATA = 2'd1,
      ST_RESP      = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int   TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   // Register address for each step of the sequence.
   function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] step_addr(input logic [1:0] step);
      logic [C_M_AXI_ADDR_WIDTH-1:0] a;
      case (step)
         2'd0:    a = C_M_AXI_ADDR_WIDTH'(8'h04);
         2'd1:    a = C_M_AXI_ADDR_WIDTH'(8'h08);
         default: a = C_M_AXI_ADDR_WIDTH'(8'h00);
      endcase
      return a;
   endfunction

   // Write data for each step; step 2 sets reload (bit1), step 3 clears it.
   function automatic logic [C_M_AXI_DATA_WIDTH-1:0] step_data(
      input logic [1:0]                 step,
      input logic                       rw,
      input logic [BRAM_ADDR_WIDTH-1:0] s_addr,
      input logic [BRAM_ADDR_WIDTH-1:0] e_addr
   );
      logic [C_M_AXI_DATA_WIDTH-1:0] d;
      case (step)
         2'd0:    d = C_M_AXI_DATA_WIDTH'(s_addr);
         2'd1:    d = C_M_AXI_DATA_WIDTH'(e_addr);
         2'd2:    d = C_M_AXI_DATA_WIDTH'({1'b1, rw});
         default: d = C_M_AXI_DATA_WIDTH'(rw);
      endcase
      return d;
   endfunction

   state_t                         r_state, w_state_nxt;
   logic [1:0]                     r_step, w_step_nxt;
   logic                           r_rw;
   logic [BRAM_ADDR_WIDTH-1:0]     r_start, r_end;
   logic [TW-1:0]                  r_tmo, w_tmo_d;
   logic                           r_awvalid, w_awvalid_d;
   logic                           r_wvalid, w_wvalid_d;
   logic                           r_bready, w_bready_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]  r_awaddr, w_awaddr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]  r_wdata, w_wdata_d;
   logic                           r_cmd_ready, w_cmd_ready_d;
   logic                           r_busy, w_busy_d;
   logic                           r_done, w_done_d;
   logic                           r_error, w_error_d;

   logic w_accept, w_aw_ok, w_w_ok, w_b_hs, w_tmo, w_enter_ad;
   logic w_rw_src;
   logic [BRAM_ADDR_WIDTH-1:0] w_start_src, w_end_src;

   assign w_accept = cmd_valid & r_cmd_ready;
   // A channel is satisfied once its handshake is done or happening now.
   assign w_aw_ok  = ~r_awvalid | m00_axi_awready;
   assign w_w_ok   = ~r_wvalid | m00_axi_wready;
   assign w_b_hs   = r_bready & m00_axi_bvalid;
   assign w_tmo    = TMO_EN && ((r_state == ST_ADDR_DATA) || (r_state == ST_RESP))
                     && (r_tmo == TMO_LAST);
   // In IDLE the command fields are not latched yet, so use the inputs.
   assign w_rw_src    = (r_state == ST_IDLE) ? cmd_rw         : r_rw;
   assign w_start_src = (r_state == ST_IDLE) ? cmd_start_addr : r_start;
   assign w_end_src   = (r_state == ST_IDLE) ? cmd_end_addr   : r_end;

   // State and step register.
   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) begin
         r_state <= ST_IDLE;
         r_step  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
      end
   end

   // Next-state logic: sequence stepping, error abort and timeout abort.
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_ADDR_DATA;
               w_step_nxt  = 2'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ADDR_DATA: begin
            if (w_tmo) begin
               w_state_nxt = ST_DONE;
            end else if (w_aw_ok && w_w_ok) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_ADDR_DATA;
            end
         end
         ST_RESP: begin
            if (w_tmo) begin
               w_state_nxt = ST_DONE;
            end else if (w_b_hs && (m00_axi_bresp != 2'b00)) begin
               w_state_nxt = ST_DONE;
            end else if (w_b_hs && (r_step == 2'd3)) begin
               w_state_nxt = ST_DONE;
            end else if (w_b_hs) begin
               w_state_nxt = ST_ADDR_DATA;
               w_step_nxt  = r_step + 2'd1;
            end else begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs and timeout counter.
   always_comb begin
      w_enter_ad    = (w_state_nxt == ST_ADDR_DATA) && (r_state != ST_ADDR_DATA);
      w_bready_d    = (w_state_nxt == ST_RESP);
      w_cmd_ready_d = (w_state_nxt == ST_IDLE);
      w_busy_d      = (w_state_nxt != ST_IDLE);
      w_done_d      = (w_state_nxt == ST_DONE);

      if (w_enter_ad) begin
         w_awvalid_d = 1'b1;
      end else if ((w_state_nxt != ST_ADDR_DATA) || (r_awvalid && m00_axi_awready)) begin
         w_awvalid_d = 1'b0;
      end else begin
         w_awvalid_d = r_awvalid;
      end

      if (w_enter_ad) begin
         w_wvalid_d = 1'b1;
      end else if ((w_state_nxt != ST_ADDR_DATA) || (r_wvalid && m00_axi_wready)) begin
         w_wvalid_d = 1'b0;
      end else begin
         w_wvalid_d = r_wvalid;
      end

      if (w_enter_ad) begin
         w_awaddr_d = step_addr(w_step_nxt);
         w_wdata_d  = step_data(w_step_nxt, w_rw_src, w_start_src, w_end_src);
      end else begin
         w_awaddr_d = r_awaddr;
         w_wdata_d  = r_wdata;
      end

      if (w_accept) begin
         w_error_d = 1'b0;
      end else if (w_tmo || ((r_state == ST_RESP) && w_b_hs && (m00_axi_bresp != 2'b00))) begin
         w_error_d = 1'b1;
      end else begin
         w_error_d = r_error;
      end

      if (w_enter_ad) begin
         w_tmo_d = '0;
      end else if (TMO_EN && ((r_state == ST_ADDR_DATA) || (r_state == ST_RESP))) begin
         w_tmo_d = r_tmo + TW'(1);
      end else begin
         w_tmo_d = r_tmo;
      end
   end

   // Output, timeout and latched-command registers.
   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) begin
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_awaddr    <= '0;
         r_wdata     <= '0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_tmo       <= '0;
         r_rw        <= 1'b0;
         r_start     <= '0;
         r_end       <= '0;
      end else begin
         r_awvalid   <= w_awvalid_d;
         r_wvalid    <= w_wvalid_d;
         r_bready    <= w_bready_d;
         r_awaddr    <= w_awaddr_d;
         r_wdata     <= w_wdata_d;
         r_cmd_ready <= w_cmd_ready_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_error     <= w_error_d;
         r_tmo       <= w_tmo_d;
         if (w_accept) begin
            r_rw    <= cmd_rw;
            r_start <= cmd_start_addr;
            r_end   <= cmd_end_addr;
         end
      end
   end

   assign cmd_ready       = r_cmd_ready;
   assign busy            = r_busy;
   assign done            = r_done;
   assign error           = r_error;
   assign m00_axi_awaddr  = r_awaddr;
   assign m00_axi_awprot  = 3'b000;
   assign m00_axi_awvalid = r_awvalid;
   assign m00_axi_wdata   = r_wdata;
   assign m00_axi_wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
   assign m00_axi_wvalid  = r_wvalid;
   assign m00_axi_bready  = r_bready;

endmodule
